// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the character-LCD command driver.
//   lcd_state_e   - controller FSM states
//   INIT_LEN      - number of bytes in the power-on init sequence
//   *_BIT         - field positions inside the LSU LCD register word
//   init_byte()   - init ROM lookup
//   is_long_cmd() - selects the long execution wait (clear display)
//   umax()        - helper used to size the delay counter
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } lcd_state_e;

    localparam int unsigned INIT_LEN = 6;

    localparam int unsigned ON_BIT  = 31;
    localparam int unsigned TOG_BIT = 30;
    localparam int unsigned RS_BIT  = 8;

    // Function set 8-bit/2-line x3, display on, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0, 3'd1, 3'd2: b = 8'h38;
            3'd3:             b = 8'h0C;
            3'd4:             b = 8'h01;
            3'd5:             b = 8'h06;
            default:          b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
        return !rs && (b[7:1] == 7'd0) && (b != 8'h00);
    endfunction

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// lcd_delay_cnt: loadable down-counter that saturates at zero.
//   i_clk, i_reset  - clock, async active-high reset (counter -> RST_VAL)
//   i_load          - load i_load_val this cycle
//   i_load_val      - value to load
//   o_value         - current count
//   o_zero          - count is zero
module lcd_delay_cnt #(
    parameter int unsigned     W       = 8,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic [W-1:0] o_value,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_value = r_cnt;
    assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/lcd_cmd_driver.sv
// lcd_cmd_driver: turns command/data bytes from the LSU LCD register into
// timed HD44780 write cycles (setup / EN pulse / hold) followed by an
// execution wait.
//   i_clk, i_reset - clock, async active-high reset
//   i_lcd_reg      - [31]=ON, [30]=issue toggle, [8]=RS, [7:0]=byte
//   o_lcd_data     - LCD data bus
//   o_lcd_rs       - register select (0 command, 1 data)
//   o_lcd_rw       - always 0 (write only)
//   o_lcd_en       - enable strobe
//   o_lcd_on       - registered i_lcd_reg[31]
//   o_busy         - transfer, wait or init in progress, or byte pending
//   o_overrun      - sticky: pending byte overwritten before issue
// Build option: define LCD_INIT_SEQ_EN to run the power-on init sequence
// in hardware after reset.
module lcd_cmd_driver
    import lcd_pkg::*;
#(
    parameter int unsigned SETUP_CYC     = 4,
    parameter int unsigned PULSE_CYC     = 12,
    parameter int unsigned HOLD_CYC      = 4,
    parameter int unsigned EXEC_CYC      = 2000,
    parameter int unsigned LONG_EXEC_CYC = 82000,
    parameter int unsigned POWERUP_CYC   = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overrun
);

    localparam int unsigned MAX_CYC = umax(umax(umax(SETUP_CYC, PULSE_CYC), umax(HOLD_CYC, EXEC_CYC)),
                                           umax(LONG_EXEC_CYC, POWERUP_CYC));
    localparam int unsigned CW = $clog2(MAX_CYC + 1);

    // Counter is loaded with N-1 so a state lasts exactly N cycles.
    localparam logic [CW-1:0] L_SETUP = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] L_PULSE = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] L_HOLD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] L_EXEC  = CW'(EXEC_CYC - 1);
    localparam logic [CW-1:0] L_LONG  = CW'(LONG_EXEC_CYC - 1);

`ifdef LCD_INIT_SEQ_EN
    localparam lcd_state_e    RST_STATE = ST_PWRUP;
    localparam logic [CW-1:0] RST_CNT   = CW'(POWERUP_CYC - 1);
`else
    localparam lcd_state_e    RST_STATE = ST_IDLE;
    localparam logic [CW-1:0] RST_CNT   = '0;
`endif

    lcd_state_e    r_state;
    lcd_state_e    w_next;
    logic          w_load;
    logic [CW-1:0] w_load_val;
    logic          w_pop;
    logic          w_zero;
    logic [CW-1:0] w_cnt_unused;
    logic          w_capture;
    logic          w_en;
    logic          w_busy;

    logic          r_tog_prev;
    logic          r_pend_v;
    logic          r_pend_rs;
    logic [7:0]    r_pend_b;
    logic [7:0]    r_data;
    logic          r_rs;
    logic          r_on;
    logic          r_overrun;
`ifdef LCD_INIT_SEQ_EN
    logic          w_init_issue;
    logic [2:0]    r_init_idx;
`endif

    logic          w_unused_bits;
    assign w_unused_bits = ^i_lcd_reg[29:9];

    lcd_delay_cnt #(
        .W       (CW),
        .RST_VAL (RST_CNT)
    ) u_delay (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_value    (w_cnt_unused),
        .o_zero     (w_zero)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        w_pop      = 1'b0;
`ifdef LCD_INIT_SEQ_EN
        w_init_issue = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (r_pend_v) begin
                    w_next     = ST_SETUP;
                    w_pop      = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = L_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_zero) begin
                    w_next     = ST_PULSE;
                    w_load     = 1'b1;
                    w_load_val = L_PULSE;
                end
            end
            ST_PULSE: begin
                if (w_zero) begin
                    w_next     = ST_HOLD;
                    w_load     = 1'b1;
                    w_load_val = L_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_zero) begin
                    w_next     = ST_EXEC;
                    w_load     = 1'b1;
                    w_load_val = is_long_cmd(r_rs, r_data) ? L_LONG : L_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_zero) begin
`ifdef LCD_INIT_SEQ_EN
                    w_next = (r_init_idx != 3'(INIT_LEN)) ? ST_INIT : ST_IDLE;
`else
                    w_next = ST_IDLE;
`endif
                end
            end
`ifdef LCD_INIT_SEQ_EN
            ST_PWRUP: begin
                if (w_zero) begin
                    w_next = ST_INIT;
                end
            end
            ST_INIT: begin
                w_init_issue = 1'b1;
                w_next       = ST_SETUP;
                w_load       = 1'b1;
                w_load_val   = L_SETUP;
            end
`endif
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        w_en   = (r_state == ST_PULSE);
        w_busy = (r_state != ST_IDLE) || r_pend_v;
    end

    assign w_capture = (i_lcd_reg[TOG_BIT] != r_tog_prev);

    // Issue detect, pending slot and output data registers
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tog_prev <= 1'b0;
            r_pend_v   <= 1'b0;
            r_pend_rs  <= 1'b0;
            r_pend_b   <= '0;
            r_data     <= '0;
            r_rs       <= 1'b0;
            r_on       <= 1'b0;
            r_overrun  <= 1'b0;
`ifdef LCD_INIT_SEQ_EN
            r_init_idx <= '0;
`endif
        end else begin
            r_tog_prev <= i_lcd_reg[TOG_BIT];
            r_on       <= i_lcd_reg[ON_BIT];
            // A capture in the same cycle as a pop refills the slot, so it
            // is not an overwrite.
            if (w_capture) begin
                r_pend_v  <= 1'b1;
                r_pend_rs <= i_lcd_reg[RS_BIT];
                r_pend_b  <= i_lcd_reg[7:0];
                if (r_pend_v && !w_pop) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_pop) begin
                r_pend_v <= 1'b0;
            end
            if (w_pop) begin
                r_rs   <= r_pend_rs;
                r_data <= r_pend_b;
            end
`ifdef LCD_INIT_SEQ_EN
            if (w_init_issue) begin
                r_rs       <= 1'b0;
                r_data     <= init_byte(r_init_idx);
                r_init_idx <= r_init_idx + 3'd1;
            end
`endif
        end
    end

    assign o_lcd_data = r_data;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = w_en;
    assign o_lcd_on   = r_on;
    assign o_busy     = w_busy;
    assign o_overrun  = r_overrun;

endmodule
